// File: rtl/fuzz_harness_pkg.sv
// Shared widths, LFSR/MISR constants, FSM state type and LFSR helpers for the
// fuzz stimulus harness.
package fuzz_harness_pkg;

  localparam int unsigned Y_W   = 350;
  localparam int unsigned W0_W  = 17;
  localparam int unsigned W1_W  = 9;
  localparam int unsigned W2_W  = 3;
  localparam int unsigned W3_W  = 14;
  localparam int unsigned W4_W  = 6;
  localparam int unsigned VEC_W = 16;
  localparam int unsigned SIG_W = 32;

  localparam logic [63:0]      LFSR_TAPS         = 64'hD800_0000_0000_0000;
  localparam logic [SIG_W-1:0] MISR_POLY_DEFAULT = 32'h04C1_1DB7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  // Galois right-shift step: taps applied when the shifted-out bit is set.
  function automatic logic [63:0] lfsr_next(input logic [63:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  function automatic logic [63:0] seed_norm(input logic [63:0] s);
    return (s == '0) ? 64'h1 : s;
  endfunction

endpackage

// File: rtl/fuzz_stim_driver_if.sv
// Control/stimulus/response bundle between the harness driver and its fuzz DUT.
// Trace signals exist only when FUZZ_TRACE_EN is defined.
interface fuzz_stim_driver_if;
  import fuzz_harness_pkg::*;

  logic             start;
  logic [Y_W-1:0]   y_in;
  logic [W0_W-1:0]  drv_wire0;
  logic [W1_W-1:0]  drv_wire1;
  logic [W2_W-1:0]  drv_wire2;
  logic [W3_W-1:0]  drv_wire3;
  logic [W4_W-1:0]  drv_wire4;
  logic             busy;
  logic             done;
  logic [VEC_W-1:0] vec_count;
  logic [SIG_W-1:0] signature;
`ifdef FUZZ_TRACE_EN
  logic             trace_valid;
  logic [SIG_W-1:0] trace_fold;
`endif

  modport master (
    input  start, y_in,
    output drv_wire0, drv_wire1, drv_wire2, drv_wire3, drv_wire4,
    output busy, done, vec_count, signature
`ifdef FUZZ_TRACE_EN
    , output trace_valid, trace_fold
`endif
  );

  modport slave (
    output start, y_in,
    input  drv_wire0, drv_wire1, drv_wire2, drv_wire3, drv_wire4,
    input  busy, done, vec_count, signature
`ifdef FUZZ_TRACE_EN
    , input trace_valid, trace_fold
`endif
  );

endinterface

// File: rtl/fuzz_misr32.sv
// 32-bit MISR: XOR-folds a wide response word into 32 bits, then shifts it into
// the signature register with polynomial feedback. clr has priority over en.
module fuzz_misr32
  import fuzz_harness_pkg::*;
#(
  parameter logic [SIG_W-1:0] POLY   = MISR_POLY_DEFAULT,
  parameter int unsigned      DATA_W = Y_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [SIG_W-1:0]  fold,
  output logic [SIG_W-1:0]  sig
);

  localparam int unsigned SLICES = (DATA_W + SIG_W - 1) / SIG_W;
  localparam int unsigned PAD_W  = SLICES * SIG_W;

  logic [PAD_W-1:0] padded;

  assign padded = PAD_W'(data);

  always_comb begin
    fold = '0;
    for (int unsigned i = 0; i < SLICES; i++) begin
      fold = fold ^ padded[i*SIG_W +: SIG_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
    end
  end

endmodule

// File: rtl/fuzz_stim_driver.sv
// Pseudo-random stimulus driver for a generated fuzz DUT: drive, settle, then
// MISR-capture the response per vector. Define FUZZ_TRACE_EN for per-vector fold trace.
module fuzz_stim_driver
  import fuzz_harness_pkg::*;
#(
  parameter int unsigned      NUM_VECTORS   = 256,
  parameter int unsigned      SETTLE_CYCLES = 2,
  parameter logic [63:0]      SEED          = 64'h1,
  parameter logic [SIG_W-1:0] MISR_POLY     = MISR_POLY_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  fuzz_stim_driver_if.master  bus
);

  if (NUM_VECTORS < 1 || NUM_VECTORS > 65535) begin : g_bad_num_vectors
    $error("fuzz_stim_driver: NUM_VECTORS must be in 1..65535");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("fuzz_stim_driver: SETTLE_CYCLES must be >= 1");
  end

  localparam logic [63:0]      SEED_EFF  = seed_norm(SEED);
  localparam logic [VEC_W-1:0] NUM_VEC_W = VEC_W'(NUM_VECTORS);
  localparam logic [31:0]      SETTLE_W  = 32'(SETTLE_CYCLES);

  state_t           state_q, state_d;
  logic [63:0]      lfsr_q;
  logic [31:0]      settle_q;
  logic [VEC_W-1:0] vec_q;
  logic             busy_q, done_q;
  logic [W0_W-1:0]  drv0_q;
  logic [W1_W-1:0]  drv1_q;
  logic [W2_W-1:0]  drv2_q;
  logic [W3_W-1:0]  drv3_q;
  logic [W4_W-1:0]  drv4_q;
  logic             run_start, drive_en, capture_en, last_vec;
  logic [SIG_W-1:0] fold;

  always_comb begin
    state_d    = state_q;
    run_start  = 1'b0;
    drive_en   = 1'b0;
    capture_en = 1'b0;
    last_vec   = ((vec_q + 16'd1) == NUM_VEC_W);
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          run_start = 1'b1;
          state_d   = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        drive_en = 1'b1;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q <= 32'd1) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        capture_en = 1'b1;
        state_d    = last_vec ? ST_DONE : ST_DRIVE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // busy drops on the final capture edge so that DONE already shows busy=0;
  // done is registered from DONE, giving the one-cycle pulse as IDLE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= SEED_EFF;
      settle_q <= '0;
      vec_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      drv0_q   <= '0;
      drv1_q   <= '0;
      drv2_q   <= '0;
      drv3_q   <= '0;
      drv4_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_DONE);
      if (run_start) begin
        lfsr_q <= SEED_EFF;
        vec_q  <= '0;
        busy_q <= 1'b1;
      end
      if (drive_en) begin
        drv0_q   <= lfsr_q[16:0];
        drv1_q   <= lfsr_q[25:17];
        drv2_q   <= lfsr_q[28:26];
        drv3_q   <= lfsr_q[42:29];
        drv4_q   <= lfsr_q[48:43];
        lfsr_q   <= lfsr_next(lfsr_q);
        settle_q <= SETTLE_W;
      end
      if (state_q == ST_SETTLE) settle_q <= settle_q - 32'd1;
      if (capture_en) begin
        vec_q <= vec_q + 16'd1;
        if (last_vec) busy_q <= 1'b0;
      end
    end
  end

  fuzz_misr32 #(
    .POLY   (MISR_POLY),
    .DATA_W (Y_W)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (run_start),
    .en    (capture_en),
    .data  (bus.y_in),
    .fold  (fold),
    .sig   (bus.signature)
  );

  assign bus.drv_wire0 = drv0_q;
  assign bus.drv_wire1 = drv1_q;
  assign bus.drv_wire2 = drv2_q;
  assign bus.drv_wire3 = drv3_q;
  assign bus.drv_wire4 = drv4_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.vec_count = vec_q;

`ifdef FUZZ_TRACE_EN
  assign bus.trace_valid = capture_en;
  assign bus.trace_fold  = fold;
`else
  logic unused_fold;
  assign unused_fold = ^fold;
`endif

endmodule

// File: tb/tb_fuzz_stim_driver.sv
// Randomized self-checking bench for fuzz_stim_driver: four configurations checked
// cycle by cycle against a schedule-level reference model.
module tb_fuzz_stim_driver;

  localparam int ND = 4;
  localparam int unsigned N_P [ND] = '{1, 1, 4, 24};
  localparam int unsigned S_P [ND] = '{2, 2, 1, 3};
  localparam logic [63:0] SEED_P [ND] = '{64'h1, 64'h0, 64'h0123_4567_89AB_CDEF,
                                          64'hC0FF_EE00_1234_5678};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         start_v [ND];
  logic [349:0] y_v     [ND];
  logic         busy_o  [ND];
  logic         done_o  [ND];
  logic [15:0]  vec_o   [ND];
  logic [31:0]  sig_o   [ND];
  logic [48:0]  stim_o  [ND];
  logic [48:0]  stim_m  [ND];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    fuzz_stim_driver_if bus ();
    assign bus.start = start_v[g];
    assign bus.y_in  = y_v[g];
    assign busy_o[g] = bus.busy;
    assign done_o[g] = bus.done;
    assign vec_o[g]  = bus.vec_count;
    assign sig_o[g]  = bus.signature;
    assign stim_o[g] = {bus.drv_wire4, bus.drv_wire3, bus.drv_wire2, bus.drv_wire1, bus.drv_wire0};

    fuzz_stim_driver #(
      .NUM_VECTORS   (N_P[g]),
      .SETTLE_CYCLES (S_P[g]),
      .SEED          (SEED_P[g]),
      .MISR_POLY     (32'h04C1_1DB7)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  function automatic logic [63:0] m_lfsr(input logic [63:0] s);
    logic out_bit;
    out_bit = s[0];
    s = s >> 1;
    if (out_bit) s = s ^ 64'hD800_0000_0000_0000;
    return s;
  endfunction

  // Bit i of the response lands in fold bit (i mod 32).
  function automatic logic [31:0] m_fold(input logic [349:0] y);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 350; i++) r[i % 32] = r[i % 32] ^ y[i];
    return r;
  endfunction

  function automatic logic [31:0] m_misr(input logic [31:0] s, input logic [31:0] f);
    logic [31:0] n;
    n = s << 1;
    if (s[31]) n = n ^ 32'h04C1_1DB7;
    return n ^ f;
  endfunction

  function automatic logic [349:0] rand_y();
    logic [351:0] r;
    for (int i = 0; i < 11; i++) r[i*32 +: 32] = $urandom();
    return r[349:0];
  endfunction

  // smode: 0 = start pulse only, 1 = start held through restart, 2 = random start mid-run.
  // started: the start edge (t=0) already happened at the end of a previous call.
  task automatic drive_run(input int d, input bit rnd, input logic [349:0] yfix,
                           input int smode, input bit started);
    int unsigned per, total;
    logic [63:0] lf;
    logic [31:0] sig_m;
    logic [15:0] vec_m;
    logic busy_e, done_e;
    per   = S_P[d] + 2;
    total = N_P[d] * per + 1;
    lf    = (SEED_P[d] == 64'h0) ? 64'h1 : SEED_P[d];
    sig_m = '0;
    vec_m = '0;
    y_v[d] = yfix;
    for (int unsigned t = (started ? 1 : 0); t <= total + 1; t++) begin
      @(negedge clk);
      if (t == 0) start_v[d] = 1'b1;
      else if (smode == 1) start_v[d] = 1'b1;
      else if (smode == 2 && t <= total) start_v[d] = 1'($urandom_range(0, 1));
      else start_v[d] = 1'b0;
      if (rnd) y_v[d] = rand_y();
      @(posedge clk);
      if (t > 0 && t % per == 0 && t / per <= N_P[d]) begin
        sig_m = m_misr(sig_m, m_fold(y_v[d]));
        vec_m = 16'(t / per);
      end
      if (t > 0 && (t - 1) % per == 0 && (t - 1) / per < N_P[d]) begin
        stim_m[d] = lf[48:0];
        lf = m_lfsr(lf);
      end
      busy_e = (t < N_P[d] * per);
      done_e = (t == total);
      if (smode == 1 && t == total + 1) begin
        busy_e = 1'b1;
        sig_m  = '0;
        vec_m  = '0;
      end
      #1;
      checks++;
      if (busy_o[d] !== busy_e) begin
        errors++;
        $display("FAIL busy dut%0d t=%0d got %b exp %b", d, t, busy_o[d], busy_e);
      end
      checks++;
      if (done_o[d] !== done_e) begin
        errors++;
        $display("FAIL done dut%0d t=%0d got %b exp %b", d, t, done_o[d], done_e);
      end
      checks++;
      if (vec_o[d] !== vec_m) begin
        errors++;
        $display("FAIL vec_count dut%0d t=%0d got %0d exp %0d", d, t, vec_o[d], vec_m);
      end
      checks++;
      if (sig_o[d] !== sig_m) begin
        errors++;
        $display("FAIL signature dut%0d t=%0d got %h exp %h", d, t, sig_o[d], sig_m);
      end
      checks++;
      if (stim_o[d] !== stim_m[d]) begin
        errors++;
        $display("FAIL stimulus dut%0d t=%0d got %h exp %h", d, t, stim_o[d], stim_m[d]);
      end
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    for (int pass = 0; pass < 2; pass++) begin
      #1;
      for (int d = 0; d < ND; d++) begin
        checks++;
        if ({busy_o[d], done_o[d], vec_o[d], sig_o[d], stim_o[d]} !== '0) begin
          errors++;
          $display("FAIL reset_state dut%0d pass%0d got busy=%b done=%b vec=%0d sig=%h stim=%h exp all 0",
                   d, pass, busy_o[d], done_o[d], vec_o[d], sig_o[d], stim_o[d]);
        end
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
    end
  endtask

  task automatic test_single_vector();
    drive_run(0, 1'b0, '1, 0, 1'b0);
    checks++;
    if (sig_o[0] !== 32'h3FFF_FFFF) begin
      errors++;
      $display("FAIL ones_signature got %h exp 3fffffff", sig_o[0]);
    end
    checks++;
    if (vec_o[0] !== 16'd1) begin
      errors++;
      $display("FAIL ones_vec_count got %0d exp 1", vec_o[0]);
    end
    checks++;
    if (stim_o[0] !== 49'h1) begin
      errors++;
      $display("FAIL ones_stimulus got %h exp 1", stim_o[0]);
    end
    drive_run(0, 1'b0, '0, 0, 1'b0);
    checks++;
    if (sig_o[0] !== 32'h0) begin
      errors++;
      $display("FAIL zeros_signature got %h exp 0", sig_o[0]);
    end
  endtask

  task automatic test_seed_zero();
    logic [349:0] y;
    logic [31:0] exp_sig;
    y = rand_y();
    exp_sig = m_misr(32'h0, m_fold(y));
    drive_run(1, 1'b0, y, 0, 1'b0);
    checks++;
    if (sig_o[1] !== exp_sig) begin
      errors++;
      $display("FAIL seed0_signature got %h exp %h", sig_o[1], exp_sig);
    end
    checks++;
    if (stim_o[1] !== 49'h1) begin
      errors++;
      $display("FAIL seed0_stimulus got %h exp 1", stim_o[1]);
    end
  endtask

  task automatic test_multi_vector();
    drive_run(2, 1'b1, '0, 0, 1'b0);
    drive_run(2, 1'b1, '0, 0, 1'b0);
  endtask

  task automatic test_start_ignored();
    drive_run(2, 1'b1, '0, 2, 1'b0);
    drive_run(3, 1'b1, '0, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    drive_run(2, 1'b1, '0, 1, 1'b0);
    drive_run(2, 1'b1, '0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk) start_v[3] = 1'b1;
    @(posedge clk);
    @(negedge clk) start_v[3] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy_o[3] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_busy got %b exp 1", busy_o[3]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_o[3], done_o[3], vec_o[3], sig_o[3], stim_o[3]} !== '0) begin
      errors++;
      $display("FAIL midrun_reset got busy=%b done=%b vec=%0d sig=%h stim=%h exp all 0",
               busy_o[3], done_o[3], vec_o[3], sig_o[3], stim_o[3]);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int d = 0; d < ND; d++) stim_m[d] = '0;
    drive_run(3, 1'b1, '0, 0, 1'b0);
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      start_v[d] = 1'b0;
      y_v[d]     = '0;
      stim_m[d]  = '0;
    end
    test_reset();
    test_single_vector();
    test_seed_zero();
    test_multi_vector();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    drive_run(3, 1'b1, '0, 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
